// File: rtl/svi_chan_array.sv
// svi_chan_array: NCH run-time programmable WIDTH-bit stimulus channels (const/alias/count/rotate).
// Optional macro SVI_CHAN_PARITY_EN adds a registered per-channel even-parity output o_par.
module svi_chan_array #(
    parameter int NCH   = 3,
    parameter int WIDTH = 8,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [WIDTH-1:0]     cfg_data,
    input  logic                 freeze,
    input  logic [NCH*WIDTH-1:0] src_in,
    output logic [NCH*WIDTH-1:0] o_ch,
    output logic                 err_sticky
`ifdef SVI_CHAN_PARITY_EN
    ,
    output logic [NCH-1:0]       o_par
`endif
);

    localparam logic [1:0] MODE_CONST  = 2'd0;
    localparam logic [1:0] MODE_ALIAS  = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_ROTATE = 2'd3;

    // One extra bit so an index equal to NCH (e.g. 4 when NCH=4 is not possible, 3 when NCH=3) compares correctly.
    localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

    logic [1:0]       mode_q   [NCH];
    logic [1:0]       mode_nxt [NCH];
    logic [WIDTH-1:0] val_q    [NCH];
    logic [WIDTH-1:0] val_nxt  [NCH];
    logic             busy_q;
    logic             accept;
    logic             in_range;

    function automatic logic [WIDTH-1:0] reset_val(input int k);
        return (k % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    assign cfg_ready = ~busy_q;
    assign accept    = cfg_valid && !busy_q;
    assign in_range  = ({1'b0, cfg_ch} < NCH_W);

    // A write to a channel beats freeze and the channel's own mode step on that edge.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            mode_nxt[k] = mode_q[k];
            val_nxt[k]  = val_q[k];
            if (accept && in_range && (cfg_ch == CHW'(k))) begin
                mode_nxt[k] = cfg_mode;
                val_nxt[k]  = cfg_data;
            end else if (!freeze) begin
                case (mode_q[k])
                    MODE_ALIAS:  val_nxt[k] = src_in[k*WIDTH +: WIDTH];
                    MODE_COUNT:  val_nxt[k] = val_q[k] + WIDTH'(1);
                    MODE_ROTATE: val_nxt[k] = {val_q[k][WIDTH-2:0], val_q[k][WIDTH-1]};
                    default:     val_nxt[k] = val_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                mode_q[k] <= MODE_CONST;
                val_q[k]  <= reset_val(k);
            end
            busy_q     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                mode_q[k] <= mode_nxt[k];
                val_q[k]  <= val_nxt[k];
            end
            busy_q <= accept;
            if (accept && !in_range) begin
                err_sticky <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign o_ch[g*WIDTH +: WIDTH] = val_q[g];
    end

`ifdef SVI_CHAN_PARITY_EN
    // Parity is taken from the next value so it lines up with o_ch in the same cycle.
    logic [NCH-1:0] par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                par_q[k] <= ^reset_val(k);
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                par_q[k] <= ^val_nxt[k];
            end
        end
    end

    assign o_par = par_q;
`endif

endmodule

// File: tb/tb_svi_chan_array.sv
// Directed, table-driven bench for svi_chan_array (NCH=3, WIDTH=8).
// Build with SVI_CHAN_PARITY_EN defined to also check o_par.
module tb_svi_chan_array;

    localparam int NCH   = 3;
    localparam int WIDTH = 8;
    localparam int CHW   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHW-1:0]       cfg_ch;
    logic [1:0]           cfg_mode;
    logic [WIDTH-1:0]     cfg_data;
    logic                 freeze;
    logic [NCH*WIDTH-1:0] src_in;
    logic [NCH*WIDTH-1:0] o_ch;
    logic                 err_sticky;
`ifdef SVI_CHAN_PARITY_EN
    logic [NCH-1:0]       o_par;
`endif

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    svi_chan_array #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_data   (cfg_data),
        .freeze     (freeze),
        .src_in     (src_in),
        .o_ch       (o_ch),
        .err_sticky (err_sticky)
`ifdef SVI_CHAN_PARITY_EN
        ,
        .o_par      (o_par)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [1:0]  ch;
        logic [1:0]  mode;
        logic [7:0]  data;
        logic        freeze;
        logic [23:0] src;
        logic [23:0] exp_ch;
        logic        exp_ready;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] ch,
                                input logic [1:0] mode, input logic [7:0] data,
                                input logic frz, input logic [23:0] src,
                                input logic [23:0] exp_ch, input logic rdy, input logic err);
        vec_t t;
        t.rst_n = r; t.valid = v; t.ch = ch; t.mode = mode; t.data = data;
        t.freeze = frz; t.src = src; t.exp_ch = exp_ch; t.exp_ready = rdy; t.exp_err = err;
        return t;
    endfunction

    // Drive inputs on the falling edge, then let one rising edge happen and settle.
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] ch,
                                 input logic [1:0] mode, input logic [7:0] data,
                                 input logic frz, input logic [23:0] src);
        @(negedge clk);
        rst_n = r; cfg_valid = v; cfg_ch = ch; cfg_mode = mode;
        cfg_data = data; freeze = frz; src_in = src;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitReady(input int budget);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < budget) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 24'h0);
            n++;
        end
        checkOutput("wait_ready", {63'd0, cfg_ready}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_data = '0; freeze = 1'b0; src_in = '0;

        //            rst  v  ch mode data  frz src        exp_ch     rdy err
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h00FF00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h00FF00, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2, 8'hFE, 0, 24'h000000, 24'h00FE00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h00FF00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h000000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h000100, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 8'h11, 0, 24'h00005A, 24'h000211, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h00005A, 24'h00035A, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 24'h0000C3, 24'h00035A, 1, 0));
        vecs.push_back(mk(1, 1, 2, 3, 8'h81, 1, 24'h0000C3, 24'h81035A, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h0000C3, 24'h0304C3, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h0000C3, 24'h0605C3, 1, 0));
        vecs.push_back(mk(1, 1, 2, 0, 8'h3C, 1, 24'h0000C3, 24'h3C05C3, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h77, 1, 24'h0000C3, 24'h3C05C3, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h77, 1, 24'h0000C3, 24'h3C0577, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h0000C3, 24'h3C0677, 1, 0));
        vecs.push_back(mk(1, 1, 3, 0, 8'hAA, 0, 24'h0000C3, 24'h3C0777, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0, 8'hAA, 0, 24'h0000C3, 24'h3C0877, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h0000C3, 24'h3C0977, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 24'h0000C3, 24'h3C0977, 1, 1));
        vecs.push_back(mk(1, 1, 1, 3, 8'h80, 0, 24'h0000C3, 24'h3C8077, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h0000C3, 24'h3C0177, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h55, 0, 24'h000000, 24'h00FF00, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h55, 0, 24'h000000, 24'h00FF55, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h00FF00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 24'h000000, 24'h00FF00, 1, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].ch, vecs[i].mode,
                          vecs[i].data, vecs[i].freeze, vecs[i].src);
            checkOutput($sformatf("v%0d o_ch", i), {40'd0, o_ch}, {40'd0, vecs[i].exp_ch});
            checkOutput($sformatf("v%0d cfg_ready", i), {63'd0, cfg_ready}, {63'd0, vecs[i].exp_ready});
            checkOutput($sformatf("v%0d err_sticky", i), {63'd0, err_sticky}, {63'd0, vecs[i].exp_err});
`ifdef SVI_CHAN_PARITY_EN
            checkOutput($sformatf("v%0d o_par", i), {61'd0, o_par},
                        {61'd0, ^vecs[i].exp_ch[23:16], ^vecs[i].exp_ch[15:8], ^vecs[i].exp_ch[7:0]});
`endif
        end

        // Held cfg_valid: accepts on alternate edges only, ch2 reloads 00 each accept.
        begin
            logic [3:0] exp_rdy;
            logic [7:0] exp_c2 [4];
            exp_rdy = 4'b1010;
            exp_c2[0] = 8'h00; exp_c2[1] = 8'h01; exp_c2[2] = 8'h00; exp_c2[3] = 8'h01;
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, 1'b1, 2'd2, 2'd2, 8'h00, 1'b0, 24'h0);
                checkOutput($sformatf("held%0d cfg_ready", i), {63'd0, cfg_ready}, {63'd0, exp_rdy[i]});
                checkOutput($sformatf("held%0d ch2", i), {56'd0, o_ch[23:16]}, {56'd0, exp_c2[i]});
            end
            applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 24'h0);
            checkOutput("held_after ch2", {56'd0, o_ch[23:16]}, 64'h02);
        end

        waitReady(8);

`ifdef SVI_CHAN_PARITY_EN
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 8'h07, 1'b0, 24'h0);
        checkOutput("par const07 ch0", {56'd0, o_ch[7:0]}, 64'h07);
        checkOutput("par const07", {63'd0, o_par[0]}, 64'd1);
        waitReady(8);
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd2, 8'h07, 1'b0, 24'h0);
        checkOutput("par cnt07", {63'd0, o_par[0]}, 64'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 24'h0);
        checkOutput("par cnt08 ch0", {56'd0, o_ch[7:0]}, 64'h08);
        checkOutput("par cnt08", {63'd0, o_par[0]}, 64'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 24'h0);
        checkOutput("par cnt09", {63'd0, o_par[0]}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
